// File: rtl/seg_scan_pwm.sv
// seg_scan_pwm -- multiplexed N-digit seven-segment scan driver.
//
// Each digit slot of SLOT_CYC clocks has two parts. It starts with BLANK_CYC
// dead-time cycles. It then has a DRIVE phase of 16 PWM steps of STEP_CYC
// cycles each, followed by any residual cycles with the outputs inactive.
// seg_data_in, digit_en and brightness are staged on load. They are copied
// to the shadow set at the frame boundary, so a frame is never torn.
//
// Optional build macro: SEG_SCAN_BLINK_EN. It adds the blink_mask input and
// the BLINK_FRAMES parameter. Masked digits then blank on alternate groups of
// BLINK_FRAMES frames.
//
// Ports:
//   clk          system clock
//   rst_n        synchronous active-low reset
//   seg_data_in  digit k pattern at [k*SEG_W +: SEG_W], active-low segments
//   digit_en     1 = digit k displayed
//   brightness   0 = 1/16 duty .. 15 = full duty
//   load         one-cycle strobe, stages the inputs above
//   blink_mask   (SEG_SCAN_BLINK_EN only) digits that blink
//   seg_sel      digit select, active-low, registered
//   seg_data     segment drive, active-low, registered
//   frame_done   one-cycle pulse on the last cycle of the last digit slot
module seg_scan_pwm #(
   parameter int DIGITS    = 6,
   parameter int SEG_W     = 8,
   parameter int CLK_FREQ  = 50000000,
   parameter int SCAN_FREQ = 200,
   parameter int BLANK_CYC = 64
`ifdef SEG_SCAN_BLINK_EN
   ,
   parameter int BLINK_FRAMES = 100
`endif
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [DIGITS*SEG_W-1:0] seg_data_in,
   input  logic [DIGITS-1:0]       digit_en,
   input  logic [3:0]              brightness,
   input  logic                    load,
`ifdef SEG_SCAN_BLINK_EN
   input  logic [DIGITS-1:0]       blink_mask,
`endif
   output logic [DIGITS-1:0]       seg_sel,
   output logic [SEG_W-1:0]        seg_data,
   output logic                    frame_done
);

   localparam int SLOT_CYC  = CLK_FREQ / (SCAN_FREQ * DIGITS);
   localparam int DRIVE_CYC = SLOT_CYC - BLANK_CYC;
   localparam int STEP_CYC  = DRIVE_CYC / 16;

   localparam int CNT_W = $clog2(SLOT_CYC + 1);
   localparam int IDX_W = $clog2(DIGITS);
   localparam int SUB_W = $clog2(STEP_CYC + 1);

   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
   localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DRIVE_CYC - 1);
   localparam logic [CNT_W-1:0] FD_AT      = CNT_W'(DRIVE_CYC - 2);
   localparam logic [SUB_W-1:0] STEP_LAST  = SUB_W'(STEP_CYC - 1);
   localparam logic [IDX_W-1:0] LAST_DIG   = IDX_W'(DIGITS - 1);

   if (STEP_CYC < 1 || DIGITS > 16 || DIGITS < 2) begin : g_bad_cfg
      $error("seg_scan_pwm: STEP_CYC must be >= 1 and DIGITS in 2..16");
   end

   typedef enum logic {BLANK, DRIVE} state_t;
   localparam state_t START_ST = (BLANK_CYC == 0) ? DRIVE : BLANK;

   state_t                  state;
   logic [CNT_W-1:0]        cnt;
   logic [SUB_W-1:0]        step_sub;
   logic [4:0]              step_idx;   // 16 = PWM steps exhausted (residual)
   logic [IDX_W-1:0]        digit;
   logic                    load_pending;

   logic [DIGITS*SEG_W-1:0] st_data, sh_data;
   logic [DIGITS-1:0]       st_en, sh_en;
   logic [3:0]              st_bright, sh_bright;

   logic [DIGITS-1:0]       en_eff;
   logic                    active;
   logic [DIGITS-1:0]       cur_sel;
   logic [SEG_W-1:0]        cur_pat;

`ifdef SEG_SCAN_BLINK_EN
   localparam int BC_W = $clog2(BLINK_FRAMES + 1);
   localparam logic [BC_W-1:0] BLINK_LAST = BC_W'(BLINK_FRAMES - 1);

   logic [DIGITS-1:0] st_mask, sh_mask;
   logic [BC_W-1:0]   blink_cnt;
   logic              blink_phase;

   assign en_eff = sh_en & ~(blink_phase ? sh_mask : '0);
`else
   assign en_eff = sh_en;
`endif

   always_comb begin
      cur_sel = '1;
      cur_pat = '1;
      for (int unsigned k = 0; k < DIGITS; k++) begin
         if (digit == IDX_W'(k)) begin
            cur_sel[k] = 1'b0;
            cur_pat    = sh_data[k*SEG_W +: SEG_W];
         end
      end
      active = (state == DRIVE) && en_eff[digit] &&
               (step_idx < ({1'b0, sh_bright} + 5'd1));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         seg_sel      <= '1;
         seg_data     <= '1;
         frame_done   <= 1'b0;
         state        <= START_ST;
         cnt          <= '0;
         step_sub     <= '0;
         step_idx     <= '0;
         digit        <= '0;
         load_pending <= 1'b0;
         st_data      <= '1;
         st_en        <= '1;
         st_bright    <= 4'hF;
         sh_data      <= '1;
         sh_en        <= '1;
         sh_bright    <= 4'hF;
`ifdef SEG_SCAN_BLINK_EN
         st_mask      <= '0;
         sh_mask      <= '0;
         blink_cnt    <= '0;
         blink_phase  <= 1'b0;
`endif
      end else begin
         seg_sel  <= active ? cur_sel : '1;
         seg_data <= active ? cur_pat : '1;

         // Raised one cycle early so the pulse covers the slot's last cycle.
         frame_done <= (digit == LAST_DIG) && (state == DRIVE) && (cnt == FD_AT);

         case (state)
            BLANK: begin
               if (cnt == BLANK_LAST) begin
                  state <= DRIVE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DRIVE: begin
               if (cnt == DRIVE_LAST) begin
                  state    <= START_ST;
                  cnt      <= '0;
                  step_sub <= '0;
                  step_idx <= '0;
                  digit    <= (digit == LAST_DIG) ? '0 : digit + 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
                  if (step_idx != 5'd16) begin
                     if (step_sub == STEP_LAST) begin
                        step_sub <= '0;
                        step_idx <= step_idx + 5'd1;
                     end else begin
                        step_sub <= step_sub + 1'b1;
                     end
                  end
               end
            end
            default: state <= START_ST;
         endcase

         if (load) begin
            st_data   <= seg_data_in;
            st_en     <= digit_en;
            st_bright <= brightness;
`ifdef SEG_SCAN_BLINK_EN
            st_mask   <= blink_mask;
`endif
         end

         // Frame boundary: a load in this same cycle bypasses staging.
         if (frame_done) begin
            load_pending <= 1'b0;
            if (load) begin
               sh_data   <= seg_data_in;
               sh_en     <= digit_en;
               sh_bright <= brightness;
`ifdef SEG_SCAN_BLINK_EN
               sh_mask   <= blink_mask;
`endif
            end else if (load_pending) begin
               sh_data   <= st_data;
               sh_en     <= st_en;
               sh_bright <= st_bright;
`ifdef SEG_SCAN_BLINK_EN
               sh_mask   <= st_mask;
`endif
            end
         end else if (load) begin
            load_pending <= 1'b1;
         end

`ifdef SEG_SCAN_BLINK_EN
         if (frame_done) begin
            if (blink_cnt == BLINK_LAST) begin
               blink_cnt   <= '0;
               blink_phase <= ~blink_phase;
            end else begin
               blink_cnt <= blink_cnt + 1'b1;
            end
         end
`endif
      end
   end

endmodule

// File: tb/tb_seg_scan_pwm.sv
// Directed bench for seg_scan_pwm: DIGITS=4, SLOT_CYC=32, BLANK_CYC=16,
// STEP_CYC=1, so one frame is 128 cycles.
module tb_seg_scan_pwm;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] seg_data_in;
   logic [3:0]  digit_en;
   logic [3:0]  brightness;
   logic        load;
   logic [3:0]  seg_sel;
   logic [7:0]  seg_data;
   logic        frame_done;
`ifdef SEG_SCAN_BLINK_EN
   logic [3:0]  blink_mask;
`endif
   logic [3:0]  ld_mask;

   always #5 clk = ~clk;

   seg_scan_pwm #(
      .DIGITS(4), .SEG_W(8), .CLK_FREQ(12800), .SCAN_FREQ(100), .BLANK_CYC(16)
`ifdef SEG_SCAN_BLINK_EN
      , .BLINK_FRAMES(2)
`endif
   ) dut (
      .clk(clk), .rst_n(rst_n), .seg_data_in(seg_data_in), .digit_en(digit_en),
      .brightness(brightness), .load(load),
`ifdef SEG_SCAN_BLINK_EN
      .blink_mask(blink_mask),
`endif
      .seg_sel(seg_sel), .seg_data(seg_data), .frame_done(frame_done)
   );

   localparam logic [31:0] D1 = 32'hC0F9A4B0;   // digit 0 = B0
   localparam logic [31:0] D2 = 32'h99928280;

   int unsigned n_vec = 0;
   int unsigned n_bad = 0;

   // Shadow set of the previous frame: its last output cycle is seen
   // during the first cycle of the next frame.
   logic [31:0] prev_d;
   logic [3:0]  prev_en, prev_b;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Expected {seg_sel, seg_data} for frame cycle j.
   function automatic logic [11:0] exp_out(input logic [31:0] d, input logic [3:0] en,
                                           input logic [3:0] b, input int j);
      int         slot = j / 32;
      int         p    = j % 32;
      logic [3:0] s    = 4'hF;
      logic [7:0] q    = 8'hFF;
      if (p >= 16 && en[slot] && (p - 16) <= int'(b)) begin
         s[slot] = 1'b0;
         q       = d[slot*8 +: 8];
      end
      return {s, q};
   endfunction

   task automatic drive_in(input logic [31:0] d, input logic [3:0] en, input logic [3:0] b,
                           input logic [3:0] mk);
      seg_data_in = d;
      digit_en    = en;
      brightness  = b;
`ifdef SEG_SCAN_BLINK_EN
      blink_mask  = mk;
`endif
      ld_mask     = mk;
   endtask

   task automatic wait_fd(input string tag, input int budget, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!frame_done && n < budget);
      check(tag, frame_done, 1'b1);
   endtask

   // Starts on a frame_done cycle, checks the following frame cycle by cycle
   // and ends on its frame_done cycle. ld1 applies a decoy load, ld2 the real
   // one (frame cycle numbers, -1 = none).
   task automatic check_frame(input string tag, input logic [31:0] d, input logic [3:0] en,
                              input logic [3:0] b, input int ld1, input int ld2,
                              input logic [31:0] nd, input logic [3:0] nen, input logic [3:0] nb);
      logic [11:0] e;
      for (int m = 0; m < 128; m++) begin
         @(negedge clk);
         load = 1'b0;
         if (m == ld1) begin
            load = 1'b1;
            drive_in(32'h0, 4'h0, 4'h0, 4'h0);
         end
         if (m == ld2) begin
            load = 1'b1;
            drive_in(nd, nen, nb, ld_mask);
         end
         e = (m == 0) ? exp_out(prev_d, prev_en, prev_b, 127) : exp_out(d, en, b, m - 1);
         check({tag, " sel"}, seg_sel, e[11:8]);
         check({tag, " data"}, seg_data, e[7:0]);
         check({tag, " frame_done"}, frame_done, (m == 127));
      end
      prev_d  = d;
      prev_en = en;
      prev_b  = b;
   endtask

   task automatic boot(input logic [31:0] d, input logic [3:0] en, input logic [3:0] b,
                       input logic [3:0] mk);
      int n;
      rst_n = 1'b0;
      load  = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      load  = 1'b1;
      drive_in(d, en, b, mk);
      @(negedge clk);
      load = 1'b0;
      prev_d  = 32'hFFFFFFFF;
      prev_en = 4'hF;
      prev_b  = 4'hF;
      wait_fd("boot frame_done", 200, n);
   endtask

   initial begin
      int n;
      rst_n = 1'b0;
      load  = 1'b0;
      drive_in(32'h0, 4'h0, 4'h0, 4'h0);
      repeat (3) @(negedge clk);
      check("reset sel", seg_sel, 4'hF);
      check("reset data", seg_data, 8'hFF);
      check("reset frame_done", frame_done, 1'b0);

      // Full brightness, all digits.
      boot(D1, 4'hF, 4'hF, 4'h0);
      check_frame("full", D1, 4'hF, 4'hF, -1, -1, 32'h0, 4'h0, 4'h0);
      // Mid-frame loads (decoy then real, last wins) stay invisible until the boundary.
      check_frame("midload", D1, 4'hF, 4'hF, 40, 50, D1, 4'hF, 4'h3);
      // Brightness 3; a load in the frame_done cycle takes effect at that boundary.
      check_frame("bright3", D1, 4'hF, 4'h3, -1, 127, D1, 4'hA, 4'hF);
      check_frame("en1010", D1, 4'hA, 4'hF, -1, 50, D2, 4'hF, 4'hF);
      check_frame("newdata", D2, 4'hF, 4'hF, -1, -1, 32'h0, 4'h0, 4'h0);

      // Reset pulse during digit 2 DRIVE (frame cycle 85).
      repeat (86) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("midrst sel", seg_sel, 4'hF);
      check("midrst data", seg_data, 8'hFF);
      check("midrst frame_done", frame_done, 1'b0);
      wait_fd("midrst frame_done", 200, n);
      check("midrst frame length", n, 127);
      prev_d  = 32'hFFFFFFFF;
      prev_en = 4'hF;
      prev_b  = 4'hF;
      check_frame("post-rst", 32'hFFFFFFFF, 4'hF, 4'hF, -1, -1, 32'h0, 4'h0, 4'h0);

`ifdef SEG_SCAN_BLINK_EN
      // Digit 0 blinks: frames 0-1 on, 2-3 off, 4-5 on.
      boot(D1, 4'hF, 4'hF, 4'h1);
      check_frame("blink f1", D1, 4'hF, 4'hF, -1, -1, 32'h0, 4'h0, 4'h0);
      check_frame("blink f2", D1, 4'hE, 4'hF, -1, -1, 32'h0, 4'h0, 4'h0);
      check_frame("blink f3", D1, 4'hE, 4'hF, -1, -1, 32'h0, 4'h0, 4'h0);
      check_frame("blink f4", D1, 4'hF, 4'hF, -1, -1, 32'h0, 4'h0, 4'h0);
      check_frame("blink f5", D1, 4'hF, 4'hF, -1, -1, 32'h0, 4'h0, 4'h0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
